store_bin: RTL and testbench
============================

Name: store_bin

Overview:
- Write-back counterpart of the bin loader.
- After the SAT engine finishes a bin, it snapshots the engine's per-bin var states and lvl states. It then writes each var state back to the global var-state RAM, using the global var id fetched from the vars-bin RAM as the address, and writes the bin's lvl states to the global lvl-state RAM starting at the bin's base level.
- Sits between the SAT engine and the bin-manager BRAMs. apply_store_o drives the BRAM port muxes.

Parameters:
NUM_VARS_A_BIN, 8, var slots per bin
NUM_LVLS_A_BIN, 8, lvl slots per bin
WIDTH_VAR, 12, global var id width (vars-bin RAM data)
WIDTH_LVL, 16, decision level width
WIDTH_BIN_ID, 10, bin number width
WIDTH_VAR_STATES, 19, one var-state word
WIDTH_LVL_STATES, 11, one lvl-state word
ADDR_WIDTH_VAR, 9, vars-bin RAM address width
ADDR_WIDTH_VAR_STATES, 9, var-state RAM address width
ADDR_WIDTH_LVL_STATES, 9, lvl-state RAM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low
start_store  in  1  one-cycle request; honoured only in IDLE
bin_num_i  in  WIDTH_BIN_ID  bin being written back, numbered from 1
apply_store_o  out  1  high while state != IDLE (BRAM mux select)
done_store  out  1  one-cycle completion pulse
var_states_i  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  engine var states; slot k = bits [k*W +: W], slot 0 in the LSBs
lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  engine lvl states, same packing
base_lvl_i  in  WIDTH_LVL  first global level owned by the bin
cur_lvl_i  in  WIDTH_LVL  highest level reached in the bin
ram_addr_v_o  out  ADDR_WIDTH_VAR  vars-bin RAM read address
ram_data_v_i  in  WIDTH_VAR  vars-bin RAM data, 1-cycle read latency
ram_we_vs_o  out  1  var-state RAM write enable
ram_addr_vs_o  out  ADDR_WIDTH_VAR_STATES  var-state RAM write address
ram_data_vs_o  out  WIDTH_VAR_STATES  var-state RAM write data
ram_we_ls_o  out  1  lvl-state RAM write enable
ram_addr_ls_o  out  ADDR_WIDTH_LVL_STATES  lvl-state RAM write address
ram_data_ls_o  out  WIDTH_LVL_STATES  lvl-state RAM write data

Behaviour:
- FSM states: IDLE, STORE_V, STORE_L, DONE.
- Reset (rst=0 at a clk edge):
  - state <= IDLE; all counters, snapshots and pipeline regs cleared.
  - Every output reads 0 the next cycle, including write enables.
  - Applies mid-operation: any remaining writes are abandoned and no done_store is issued.
- IDLE, start_store=1 (cycle T0):
  - Capture var_states_i, lvl_states_i, base_lvl_i, cur_lvl_i.
  - Capture vbase = (bin_num_i-1)*NUM_VARS_A_BIN+1, truncated to ADDR_WIDTH_VAR.
  - Next state STORE_V, or DONE if bin_num_i==0 (no writes, done_store at T1).
- start_store outside IDLE is ignored. Inputs are not re-sampled after T0.
- STORE_V (cycles T1..T8, counter k=0..NUM_VARS_A_BIN-1):
  - ram_addr_v_o = vbase+k (combinational from counter); 0 in all other states.
  - Registered pipeline: rd_valid_q, rd_idx_q <= 1, k.
  - After the last k, go to STORE_L.
- Var write, one cycle after each read (T2..T9):
  - ram_we_vs_o = rd_valid_q && ram_data_v_i!=0. A zero var id marks an empty slot and is not written.
  - ram_addr_vs_o = ram_data_v_i[ADDR_WIDTH_VAR_STATES-1:0].
  - ram_data_vs_o = snapshot slot rd_idx_q.
  - Address/data read 0 when ram_we_vs_o=0.
  - The last var write (T9) overlaps the first STORE_L cycle; the two RAMs are independent.
- STORE_L (cycles T9..T16, counter j=0..NUM_LVLS_A_BIN-1, always NUM_LVLS_A_BIN cycles):
  - nl = 0 if cur<base; else min(cur-base+1, NUM_LVLS_A_BIN). Computed in WIDTH_LVL+1 bits, no wrap.
  - ram_we_ls_o = (j < nl).
  - ram_addr_ls_o = (base_lvl+j) truncated to ADDR_WIDTH_LVL_STATES.
  - ram_data_ls_o = snapshot lvl slot j.
  - Address/data read 0 when ram_we_ls_o=0.
  - After j=NUM_LVLS_A_BIN-1, go to DONE.
- DONE (T17): done_store=1 for exactly one cycle, then IDLE. A new start_store is accepted from T18.
- Fixed latency: start_store at T0 -> done_store at T0+NUM_VARS_A_BIN+NUM_LVLS_A_BIN+1.

Test Plan:
- bin_num_i=2, var ids 10..17 at vars-bin addresses 9..16, var slot k=0x100+k -> writes (10,0x100)..(17,0x107) at T2..T9; done_store at T17.
- Var ids {5,0,7,0,0,0,0,3} -> exactly three var writes, at addresses 5, 7, 3 with slots 0, 2, 7; no writes for the zero ids.
- base_lvl_i=4, cur_lvl_i=6, lvl slot j=0x40+j -> lvl writes (4,0x40),(5,0x41),(6,0x42) at T9..T11 only.
- base_lvl_i=3, cur_lvl_i=20 -> 8 lvl writes, addresses 3..10; cur_lvl_i=2 with base 3 -> no lvl writes; done_store still at T17 in both cases.
- bin_num_i=0 -> no writes, done_store at T1. start_store re-pulsed at T5 of a normal run -> ignored, single done_store at T17.
- rst=0 at T6 -> all outputs 0 from T7, no further writes, no done_store. A new start_store after reset completes normally.

Source files
------------

// File: rtl/store_bin.sv
// store_bin: write-back of one SAT-engine bin into the global BRAMs.
//
// On start_store (IDLE only) the engine's per-bin var/lvl states and the
// bin's level window are snapshotted. The FSM then walks the vars-bin RAM
// (STORE_V), and one cycle later (1-cycle RAM latency) writes each var
// state to the var-state RAM at the fetched global var id. It then writes
// the bin's lvl states to the lvl-state RAM starting at base_lvl (STORE_L),
// and pulses done_store (DONE).
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start_store         one-cycle request, honoured only in IDLE
//   bin_num_i           bin number (1-based; 0 = nothing to store)
//   var_states_i        packed engine var states, slot 0 in the LSBs
//   lvl_states_i        packed engine lvl states, slot 0 in the LSBs
//   base_lvl_i          first global level owned by the bin
//   cur_lvl_i           highest level reached in the bin
//   apply_store_o       high while busy; selects this block on the BRAM muxes
//   done_store          one-cycle completion pulse
//   ram_addr_v_o        vars-bin RAM read address
//   ram_data_v_i        vars-bin RAM read data (global var id)
//   ram_*_vs_o          var-state RAM write port
//   ram_*_ls_o          lvl-state RAM write port
module store_bin #(
  parameter int NUM_VARS_A_BIN        = 8,
  parameter int NUM_LVLS_A_BIN        = 8,
  parameter int WIDTH_VAR             = 12,
  parameter int WIDTH_LVL             = 16,
  parameter int WIDTH_BIN_ID          = 10,
  parameter int WIDTH_VAR_STATES      = 19,
  parameter int WIDTH_LVL_STATES      = 11,
  parameter int ADDR_WIDTH_VAR        = 9,
  parameter int ADDR_WIDTH_VAR_STATES = 9,
  parameter int ADDR_WIDTH_LVL_STATES = 9
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_store,
  input  logic [WIDTH_BIN_ID-1:0]                    bin_num_i,
  output logic                                       apply_store_o,
  output logic                                       done_store,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_i,
  input  logic [WIDTH_LVL-1:0]                       base_lvl_i,
  input  logic [WIDTH_LVL-1:0]                       cur_lvl_i,
  output logic [ADDR_WIDTH_VAR-1:0]                  ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]                       ram_data_v_i,
  output logic                                       ram_we_vs_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]           ram_addr_vs_o,
  output logic [WIDTH_VAR_STATES-1:0]                ram_data_vs_o,
  output logic                                       ram_we_ls_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]           ram_addr_ls_o,
  output logic [WIDTH_LVL_STATES-1:0]                ram_data_ls_o
);

  localparam int KW  = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1;
  localparam int JW  = (NUM_LVLS_A_BIN > 1) ? $clog2(NUM_LVLS_A_BIN) : 1;
  localparam int NLW = WIDTH_LVL + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STORE_V = 2'd1;
  localparam logic [1:0] S_STORE_L = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]                                 state_q, state_d;
  logic [KW-1:0]                              k_q, k_d;
  logic [JW-1:0]                              j_q, j_d;
  logic                                       rd_valid_q, rd_valid_d;
  logic [KW-1:0]                              rd_idx_q, rd_idx_d;
  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_snap_q, var_snap_d;
  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_snap_q, lvl_snap_d;
  logic [WIDTH_LVL-1:0]                       base_q, base_d;
  logic [WIDTH_LVL-1:0]                       cur_q, cur_d;
  logic [ADDR_WIDTH_VAR-1:0]                  vbase_q, vbase_d;

  logic [ADDR_WIDTH_VAR-1:0]                  vbase_s;
  logic [NLW-1:0]                             span_s;
  logic [NLW-1:0]                             nl_s;

  // First vars-bin address of the bin: bins are 1-based, slot 0 of the RAM is unused.
  assign vbase_s = ADDR_WIDTH_VAR'((32'(bin_num_i) - 32'd1) * 32'(NUM_VARS_A_BIN) + 32'd1);

  // Number of live levels in the bin, clamped to the slot count; extra bit avoids wrap.
  always_comb begin
    span_s = {1'b0, cur_q} - {1'b0, base_q} + NLW'(1);
    if (cur_q < base_q) begin
      nl_s = '0;
    end else if (span_s > NLW'(NUM_LVLS_A_BIN)) begin
      nl_s = NLW'(NUM_LVLS_A_BIN);
    end else begin
      nl_s = span_s;
    end
  end

  // FSM next-state, counters, snapshot capture and read pipeline.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    rd_valid_d = 1'b0;
    rd_idx_d   = rd_idx_q;
    var_snap_d = var_snap_q;
    lvl_snap_d = lvl_snap_q;
    base_d     = base_q;
    cur_d      = cur_q;
    vbase_d    = vbase_q;
    case (state_q)
      S_IDLE: begin
        if (start_store) begin
          var_snap_d = var_states_i;
          lvl_snap_d = lvl_states_i;
          base_d     = base_lvl_i;
          cur_d      = cur_lvl_i;
          vbase_d    = vbase_s;
          k_d        = '0;
          j_d        = '0;
          state_d    = (bin_num_i == '0) ? S_DONE : S_STORE_V;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STORE_V: begin
        // Tag the read issued this cycle; its data arrives next cycle.
        rd_valid_d = 1'b1;
        rd_idx_d   = k_q;
        if (k_q == KW'(NUM_VARS_A_BIN - 1)) begin
          k_d     = '0;
          state_d = S_STORE_L;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_STORE_L: begin
        if (j_q == JW'(NUM_LVLS_A_BIN - 1)) begin
          j_d     = '0;
          state_d = S_DONE;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      j_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      var_snap_q <= '0;
      lvl_snap_q <= '0;
      base_q     <= '0;
      cur_q      <= '0;
      vbase_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      var_snap_q <= var_snap_d;
      lvl_snap_q <= lvl_snap_d;
      base_q     <= base_d;
      cur_q      <= cur_d;
      vbase_q    <= vbase_d;
    end
  end

  // Output decode; address/data are forced to 0 whenever the matching write enable is low.
  always_comb begin
    apply_store_o = (state_q != S_IDLE);
    done_store    = (state_q == S_DONE);
    ram_addr_v_o  = '0;
    ram_we_vs_o   = 1'b0;
    ram_addr_vs_o = '0;
    ram_data_vs_o = '0;
    ram_we_ls_o   = 1'b0;
    ram_addr_ls_o = '0;
    ram_data_ls_o = '0;
    if (state_q == S_STORE_V) begin
      ram_addr_v_o = vbase_q + ADDR_WIDTH_VAR'(k_q);
    end else begin
      ram_addr_v_o = '0;
    end
    // A zero var id marks an empty slot in the vars-bin RAM.
    if (rd_valid_q && (ram_data_v_i != '0)) begin
      ram_we_vs_o   = 1'b1;
      ram_addr_vs_o = ram_data_v_i[ADDR_WIDTH_VAR_STATES-1:0];
      ram_data_vs_o = var_snap_q[int'(rd_idx_q)*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
    end else begin
      ram_we_vs_o = 1'b0;
    end
    if ((state_q == S_STORE_L) && (NLW'(j_q) < nl_s)) begin
      ram_we_ls_o   = 1'b1;
      ram_addr_ls_o = ADDR_WIDTH_LVL_STATES'(base_q + WIDTH_LVL'(j_q));
      ram_data_ls_o = lvl_snap_q[int'(j_q)*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
    end else begin
      ram_we_ls_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_bin.sv
// Self-checking bench for store_bin: table of directed bins, each run for
// 18 cycles after start_store with every output compared per cycle against
// values derived from the table row, plus per-run write counts.
module tb_store_bin;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_store;
  logic [9:0]    bin_num_i;
  logic          apply_store_o;
  logic          done_store;
  logic [151:0]  var_states_i;
  logic [87:0]   lvl_states_i;
  logic [15:0]   base_lvl_i;
  logic [15:0]   cur_lvl_i;
  logic [8:0]    ram_addr_v_o;
  logic [11:0]   ram_data_v_i;
  logic          ram_we_vs_o;
  logic [8:0]    ram_addr_vs_o;
  logic [18:0]   ram_data_vs_o;
  logic          ram_we_ls_o;
  logic [8:0]    ram_addr_ls_o;
  logic [10:0]   ram_data_ls_o;

  int errors = 0;
  int checks = 0;

  logic [11:0] vbram [512];

  store_bin dut (
    .clk(clk), .rst(rst), .start_store(start_store), .bin_num_i(bin_num_i),
    .apply_store_o(apply_store_o), .done_store(done_store),
    .var_states_i(var_states_i), .lvl_states_i(lvl_states_i),
    .base_lvl_i(base_lvl_i), .cur_lvl_i(cur_lvl_i),
    .ram_addr_v_o(ram_addr_v_o), .ram_data_v_i(ram_data_v_i),
    .ram_we_vs_o(ram_we_vs_o), .ram_addr_vs_o(ram_addr_vs_o), .ram_data_vs_o(ram_data_vs_o),
    .ram_we_ls_o(ram_we_ls_o), .ram_addr_ls_o(ram_addr_ls_o), .ram_data_ls_o(ram_data_ls_o)
  );

  always #5 clk = ~clk;

  // vars-bin RAM model, 1-cycle read latency
  always @(posedge clk) ram_data_v_i <= vbram[ram_addr_v_o];

  // mode: 0 normal, 1 start re-pulsed at T5, 2 reset asserted at T6
  typedef struct {
    logic [9:0]  bin;
    logic [8:0]  vbase;
    logic [95:0] ids;
    logic [18:0] vs0;
    logic [10:0] ls0;
    logic [15:0] base;
    logic [15:0] cur;
    int          nl;
    int          nvw;
    int          nlw;
    int          mode;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [95:0] mk_ids(input logic [11:0] i0, i1, i2, i3, i4, i5, i6, i7);
    return {i7, i6, i5, i4, i3, i2, i1, i0};
  endfunction

  task automatic chk(input string name, input int c, input int t,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s case=%0d t=%0d: got %h expected %h", name, c, t, act, exp);
    end
  endtask

  task automatic run_case(input int c);
    vec_t v;
    int nvw;
    int nlw;
    int k;
    int j;
    logic [11:0] id;
    logic        live;
    logic [10:0] e_ctrl;
    logic [28:0] e_var;
    logic [20:0] e_lvl;
    v = tbl[c];
    for (int i = 0; i < 8; i++) vbram[9'(v.vbase + 9'(i))] = v.ids[i*12 +: 12];
    @(negedge clk);
    bin_num_i  = v.bin;
    base_lvl_i = v.base;
    cur_lvl_i  = v.cur;
    for (int i = 0; i < 8; i++) begin
      var_states_i[i*19 +: 19] = v.vs0 + 19'(i);
      lvl_states_i[i*11 +: 11] = v.ls0 + 11'(i);
    end
    start_store = 1'b1;
    nvw = 0;
    nlw = 0;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      live   = !(v.mode == 2 && t >= 7);
      e_ctrl = '0;
      e_var  = '0;
      e_lvl  = '0;
      if (v.bin == 10'd0) begin
        if (t == 1) e_ctrl = {1'b1, 1'b1, 9'd0};
      end else if (live) begin
        e_ctrl[10] = (t <= 17);
        e_ctrl[9]  = (t == 17);
        if (t >= 1 && t <= 8) e_ctrl[8:0] = v.vbase + 9'(t - 1);
        if (t >= 2 && t <= 9) begin
          k  = t - 2;
          id = v.ids[k*12 +: 12];
          if (id != 12'd0) e_var = {1'b1, id[8:0], v.vs0 + 19'(k)};
        end
        if (t >= 9 && t <= 16) begin
          j = t - 9;
          if (j < v.nl) e_lvl = {1'b1, 9'(v.base + 16'(j)), v.ls0 + 11'(j)};
        end
      end
      chk("ctrl{apply,done,addr_v}", c, t, 64'({apply_store_o, done_store, ram_addr_v_o}), 64'(e_ctrl));
      chk("var_write{we,addr,data}", c, t, 64'({ram_we_vs_o, ram_addr_vs_o, ram_data_vs_o}), 64'(e_var));
      chk("lvl_write{we,addr,data}", c, t, 64'({ram_we_ls_o, ram_addr_ls_o, ram_data_ls_o}), 64'(e_lvl));
      if (ram_we_vs_o) nvw++;
      if (ram_we_ls_o) nlw++;
      // inputs must not be re-sampled after T0
      if (t == 1) begin
        start_store  = 1'b0;
        var_states_i = ~var_states_i;
        lvl_states_i = ~lvl_states_i;
        base_lvl_i   = ~base_lvl_i;
        cur_lvl_i    = ~cur_lvl_i;
        bin_num_i    = ~bin_num_i;
      end
      if (v.mode == 1 && t == 5) start_store = 1'b1;
      if (v.mode == 1 && t == 6) start_store = 1'b0;
      if (v.mode == 2 && t == 6) rst = 1'b0;
      if (v.mode == 2 && t == 7) rst = 1'b1;
    end
    chk("var_write_count", c, 0, 64'(nvw), 64'(v.nvw));
    chk("lvl_write_count", c, 0, 64'(nlw), 64'(v.nlw));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) vbram[i] = 12'd0;
    tbl[0] = '{10'd2,  9'd9,  mk_ids(12'd10, 12'd11, 12'd12, 12'd13, 12'd14, 12'd15, 12'd16, 12'd17),
               19'h100, 11'h040, 16'd4, 16'd6, 3, 8, 3, 0};
    tbl[1] = '{10'd3,  9'd17, mk_ids(12'd5, 12'd0, 12'd7, 12'd0, 12'd0, 12'd0, 12'd0, 12'd3),
               19'h200, 11'h010, 16'd3, 16'd20, 8, 3, 8, 0};
    tbl[2] = '{10'd1,  9'd1,  mk_ids(12'd20, 12'd21, 12'd22, 12'd23, 12'd24, 12'd25, 12'd26, 12'd27),
               19'h7FFF0, 11'h7F8, 16'd3, 16'd2, 0, 8, 0, 0};
    tbl[3] = '{10'd0,  9'd0,  mk_ids(12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0),
               19'h0, 11'h0, 16'd5, 16'd9, 0, 0, 0, 0};
    tbl[4] = '{10'd65, 9'd1,  mk_ids(12'hFFF, 12'h200, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'h1FF),
               19'h030, 11'h050, 16'd510, 16'd513, 4, 4, 4, 0};
    tbl[5] = '{10'd5,  9'd33, mk_ids(12'd30, 12'd31, 12'd32, 12'd33, 12'd34, 12'd35, 12'd36, 12'd37),
               19'h111, 11'h222, 16'hFFFE, 16'hFFFF, 2, 8, 2, 1};
    tbl[6] = '{10'd4,  9'd25, mk_ids(12'd40, 12'd41, 12'd42, 12'd43, 12'd44, 12'd45, 12'd46, 12'd47),
               19'h300, 11'h300, 16'd0, 16'hFFFF, 8, 5, 0, 2};
    tbl[7] = '{10'd2,  9'd9,  mk_ids(12'd50, 12'd51, 12'd52, 12'd53, 12'd54, 12'd55, 12'd56, 12'd57),
               19'h400, 11'h100, 16'd0, 16'd0, 1, 8, 1, 0};

    rst          = 1'b0;
    start_store  = 1'b0;
    bin_num_i    = '0;
    var_states_i = '0;
    lvl_states_i = '0;
    base_lvl_i   = '0;
    cur_lvl_i    = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", -1, 0,
        64'({apply_store_o, done_store, ram_addr_v_o, ram_we_vs_o, ram_addr_vs_o, ram_data_vs_o}), 64'd0);
    chk("reset_lvl_outputs", -1, 0, 64'({ram_we_ls_o, ram_addr_ls_o, ram_data_ls_o}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 8; c++) run_case(c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
